servo_pwm_gen: RTL and testbench



---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_pwm_gen_if.sv | 29 ++
 rtl/servo_pwm_channel.sv | 45 ++++
 rtl/servo_pwm_gen.sv | 87 ++++++++
 tb/tb_servo_pwm_gen.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo drive constants and pulse width helper
//
// Purpose: default timing for the servo pulse generator, the command/counter
// widths shared with the steering block, and the pulse width rule.
// Ports: none (package).
package servo_pkg;

  localparam int CMD_W = 8;
  localparam int US_W  = 16;

  localparam logic [CMD_W-1:0] CMD_IDLE = '0;

  localparam int DEF_TICK_DIV      = 100;
  localparam int DEF_FRAME_US      = 20000;
  localparam int DEF_PULSE_BASE_US = 1000;
  localparam int DEF_PULSE_STEP_US = 4;

  // Pulse width in microsecond ticks for a given command.
  function automatic logic [US_W-1:0] pulse_width(input int base, input int step,
                                                  input logic [CMD_W-1:0] cmd);
    return US_W'(base + int'(cmd) * step);
  endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// rtl/servo_pwm_gen_if.sv - command and pin bundle between steering logic and servo generator
//
// Purpose: groups the drive enable, both speed commands and the generator outputs.
// Signals: en, cmd_l, cmd_r (steering -> generator);
//          pwm_l, pwm_r, frame_start, active_l, active_r (generator -> pins/steering).
// Modports: master = steering side, slave = pulse generator.
interface servo_pwm_gen_if;
  import servo_pkg::*;

  logic             en;
  logic [CMD_W-1:0] cmd_l;
  logic [CMD_W-1:0] cmd_r;
  logic             pwm_l;
  logic             pwm_r;
  logic             frame_start;
  logic             active_l;
  logic             active_r;

  modport master (
    output en, cmd_l, cmd_r,
    input  pwm_l, pwm_r, frame_start, active_l, active_r
  );

  modport slave (
    input  en, cmd_l, cmd_r,
    output pwm_l, pwm_r, frame_start, active_l, active_r
  );

endinterface

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: frame-latched command and pulse compare
//
// Purpose: latches the command at the frame boundary, derives the pulse width
// and compares it against the shared frame counter.
// Ports: clk, rst (sync, active-high); boundary (last tick of frame);
//        en, cmd (live command); us_cnt (shared frame counter);
//        pwm (registered pin), active (latched command non-zero).
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int PULSE_BASE_US = DEF_PULSE_BASE_US,
  parameter int PULSE_STEP_US = DEF_PULSE_STEP_US
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary,
  input  logic             en,
  input  logic [CMD_W-1:0] cmd,
  input  logic [US_W-1:0]  us_cnt,
  output logic             pwm,
  output logic             active
);

  logic [CMD_W-1:0] shadow;
  logic [US_W-1:0]  width;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= CMD_IDLE;
      width  <= '0;
      pwm    <= 1'b0;
      active <= 1'b0;
    end else begin
      // Only the boundary edge may change what the current frame emits.
      if (boundary) begin
        shadow <= en ? cmd : CMD_IDLE;
        width  <= pulse_width(PULSE_BASE_US, PULSE_STEP_US, cmd);
      end
      // One clk behind the counter, so the pulse starts the clk after the boundary.
      pwm    <= (shadow != CMD_IDLE) && (us_cnt < width);
      active <= (shadow != CMD_IDLE);
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - two-channel fixed-frame servo pulse generator
//
// Purpose: shared microsecond prescaler and frame counter driving a left and a
// right servo channel; frame_start marks the first clk of every frame.
// Ports: clk, rst (sync, active-high);
//        bus (slave): en, cmd_l, cmd_r in; pwm_l, pwm_r, frame_start,
//        active_l, active_r out.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int FRAME_US      = DEF_FRAME_US,
  parameter int PULSE_BASE_US = DEF_PULSE_BASE_US,
  parameter int PULSE_STEP_US = DEF_PULSE_STEP_US
) (
  input logic           clk,
  input logic           rst,
  servo_pwm_gen_if.slave bus
);

  localparam int TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_WIDTH_US = PULSE_BASE_US + ((1 << CMD_W) - 1) * PULSE_STEP_US;

  // The widest pulse must end inside the frame or the output would never drop.
  if (MAX_WIDTH_US >= FRAME_US) begin : g_width_check
    $error("servo_pwm_gen: maximum pulse width %0d us does not fit in frame of %0d us",
           MAX_WIDTH_US, FRAME_US);
  end

  logic [TICK_W-1:0] tick_cnt;
  logic [US_W-1:0]   us_cnt;
  logic              tick;
  logic              boundary;
  logic              boundary_q;
  logic              frame_start_q;

  assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign boundary = tick && (us_cnt == US_W'(FRAME_US - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt      <= '0;
      us_cnt        <= '0;
      boundary_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) begin
        us_cnt <= boundary ? '0 : us_cnt + US_W'(1);
      end
      // Two stages so the strobe lines up with the registered pwm rising edge.
      boundary_q    <= boundary;
      frame_start_q <= boundary_q;
    end
  end

  assign bus.frame_start = frame_start_q;

  servo_pwm_channel #(
    .PULSE_BASE_US(PULSE_BASE_US),
    .PULSE_STEP_US(PULSE_STEP_US)
  ) u_ch_l (
    .clk     (clk),
    .rst     (rst),
    .boundary(boundary),
    .en      (bus.en),
    .cmd     (bus.cmd_l),
    .us_cnt  (us_cnt),
    .pwm     (bus.pwm_l),
    .active  (bus.active_l)
  );

  servo_pwm_channel #(
    .PULSE_BASE_US(PULSE_BASE_US),
    .PULSE_STEP_US(PULSE_STEP_US)
  ) u_ch_r (
    .clk     (clk),
    .rst     (rst),
    .boundary(boundary),
    .en      (bus.en),
    .cmd     (bus.cmd_r),
    .us_cnt  (us_cnt),
    .pwm     (bus.pwm_r),
    .active  (bus.active_r)
  );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - scoreboard bench for the servo pulse generator
module tb_servo_pwm_gen;
  import servo_pkg::*;

  localparam int TD        = 2;
  localparam int FR        = 300;
  localparam int BASE      = 10;
  localparam int STEP      = 1;
  localparam int FRAME_CLK = FR * TD;

  typedef struct {
    int l;
    int r;
  } want_t;

  typedef struct {
    int l;
    int r;
    bit e;
    int off;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;

  always #5 clk = ~clk;

  servo_pwm_gen_if sif ();

  servo_pwm_gen #(
    .TICK_DIV     (TD),
    .FRAME_US     (FR),
    .PULSE_BASE_US(BASE),
    .PULSE_STEP_US(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  want_t want_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  bit open, is_pre, act_l, act_r, prev_l, prev_r, fs_prev;
  int len_l, len_r, rise_l, rise_r, roff_l, roff_r, period;

  task automatic check_eq(input string tag, input int obs, input int want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int width_clk(input int c, input bit e);
    if (!e || c == 0) return 0;
    return (BASE + c * STEP) * TD;
  endfunction

  always @(posedge clk) rst_seen <= rst;

  task automatic close_frame();
    want_t w;
    check_eq("want_available", int'(want_q.size() > 0), 1);
    if (want_q.size() > 0) begin
      w = want_q.pop_front();
      check_eq("len_l", len_l, w.l);
      check_eq("len_r", len_r, w.r);
      check_eq("active_l", int'(act_l), int'(w.l != 0));
      check_eq("active_r", int'(act_r), int'(w.r != 0));
      check_eq("rises_l", rise_l, int'(w.l != 0));
      check_eq("rises_r", rise_r, int'(w.r != 0));
      if (!is_pre) begin
        check_eq("period", period, FRAME_CLK);
        if (w.l != 0) check_eq("rise_at_fs_l", roff_l, 1);
        if (w.r != 0) check_eq("rise_at_fs_r", roff_r, 1);
      end
    end
  endtask

  task automatic clear_counts();
    len_l = 0; len_r = 0; rise_l = 0; rise_r = 0;
    roff_l = 0; roff_r = 0; period = 0;
  endtask

  // Monitor: measures each frame between frame_start strobes.
  initial begin
    open = 1'b0;
    is_pre = 1'b0;
    prev_l = 1'b0; prev_r = 1'b0; fs_prev = 1'b0;
    act_l = 1'b0; act_r = 1'b0;
    clear_counts();
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check_eq("reset_outputs",
                 int'({sif.pwm_l, sif.pwm_r, sif.frame_start, sif.active_l, sif.active_r}), 0);
        open = 1'b1;
        is_pre = 1'b1;
        clear_counts();
        act_l = 1'b0; act_r = 1'b0;
        prev_l = 1'b0; prev_r = 1'b0; fs_prev = 1'b0;
      end else if (!done) begin
        if (sif.frame_start) begin
          check_eq("fs_one_clk", int'(fs_prev), 0);
          if (open) close_frame();
          open = 1'b1;
          is_pre = 1'b0;
          clear_counts();
          act_l = sif.active_l;
          act_r = sif.active_r;
        end
        if (open) begin
          period++;
          if (sif.pwm_l) len_l++;
          if (sif.pwm_r) len_r++;
          if (sif.pwm_l && !prev_l) begin rise_l++; roff_l = period; end
          if (sif.pwm_r && !prev_r) begin rise_r++; roff_r = period; end
        end
        prev_l  = sif.pwm_l;
        prev_r  = sif.pwm_r;
        fs_prev = sif.frame_start;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!sif.frame_start && n < 2 * FRAME_CLK);
    check_eq("fs_seen", int'(sif.frame_start), 1);
  endtask

  task automatic apply(input int l, input int r, input bit e);
    want_t w;
    sif.cmd_l = CMD_W'(l);
    sif.cmd_r = CMD_W'(r);
    sif.en    = e;
    w.l = width_clk(l, e);
    w.r = width_clk(r, e);
    want_q.push_back(w);
  endtask

  task automatic do_reset(input int cycles, input int l, input int r, input bit e);
    want_t silent;
    silent.l = 0;
    silent.r = 0;
    rst = 1'b1;
    step(cycles);
    want_q.delete();
    want_q.push_back(silent);
    apply(l, r, e);
    rst = 1'b0;
  endtask

  stim_t tbl [8] = '{
    '{20,  80,  1'b1, 10},
    '{50,  80,  1'b1, 30},
    '{40,  0,   1'b1, 5},
    '{40,  0,   1'b0, 50},
    '{40,  0,   1'b1, 200},
    '{0,   255, 1'b1, 0},
    '{255, 1,   1'b1, 590},
    '{20,  20,  1'b1, 10}
  };

  initial begin
    int n;
    sif.en    = 1'b0;
    sif.cmd_l = CMD_IDLE;
    sif.cmd_r = CMD_IDLE;
    step(1);
    do_reset(5, 1, 80, 1'b1);

    foreach (tbl[i]) begin
      wait_fs();
      step(tbl[i].off);
      apply(tbl[i].l, tbl[i].r, tbl[i].e);
    end

    // Reset three clk into a 60-clk pulse.
    wait_fs();
    step(2);
    do_reset(3, 20, 20, 1'b1);

    wait_fs();
    step(7);
    apply(33, 7, 1'b1);

    n = 0;
    while (want_q.size() > 0 && n < 4 * FRAME_CLK) begin
      step(1);
      n++;
    end
    check_eq("drain", want_q.size(), 0);
    done = 1'b1;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
